// File: rtl/hack_pkg.sv
// Shared Hack CPU constants: word width, PC reset vector and the PC action encoding.
package hack_pkg;

    localparam int WORD_W = 16;
    localparam logic [WORD_W-1:0] PC_RESET_VEC = '0;

    localparam logic [1:0] ACT_HOLD = 2'd0;
    localparam logic [1:0] ACT_INC  = 2'd1;
    localparam logic [1:0] ACT_LOAD = 2'd2;
    localparam logic [1:0] ACT_CLR  = 2'd3;

endpackage

// File: rtl/pc_register.sv
// WIDTH-bit register bank with write enable and asynchronous active-high reset to RST_VAL.
module pc_register #(
    parameter int WIDTH = 16,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            q <= RST_VAL;
        else if (en)
            q <= d;
    end

endmodule

// File: rtl/program_counter.sv
// Hack program counter: priority clr > load > inc > hold, with a one-cycle wrap pulse.
// Optional last_jump capture register enabled by the PC_LAST_JUMP_EN macro.
module program_counter
    import hack_pkg::*;
#(
    parameter int WIDTH = WORD_W,
    parameter logic [WIDTH-1:0] RESET_VEC = WIDTH'(PC_RESET_VEC)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic             inc,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out,
    output logic             wrap,
    output logic [WIDTH-1:0] last_jump
);

    logic [1:0]       act;
    logic             pc_en;
    logic [WIDTH-1:0] pc_inc;
    logic [WIDTH-1:0] pc_next;

    always_comb begin
        act = ACT_HOLD;
        if (inc)  act = ACT_INC;
        if (load) act = ACT_LOAD;
        if (clr)  act = ACT_CLR;
    end

    assign pc_en   = clr | load | inc;
    assign pc_inc  = out + WIDTH'(1);
    assign pc_next = clr ? RESET_VEC : (load ? in : pc_inc);

    pc_register #(.WIDTH(WIDTH), .RST_VAL(RESET_VEC)) u_pc (
        .clk (clk),
        .rst (rst),
        .en  (pc_en),
        .d   (pc_next),
        .q   (out)
    );

    // Only an increment out of all-ones raises wrap; every other edge clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            wrap <= 1'b0;
        else
            wrap <= (act == ACT_INC) && (&out);
    end

`ifdef PC_LAST_JUMP_EN
    pc_register #(.WIDTH(WIDTH), .RST_VAL('0)) u_last_jump (
        .clk (clk),
        .rst (rst),
        .en  (act == ACT_LOAD),
        .d   (out),
        .q   (last_jump)
    );
`else
    assign last_jump = '0;
`endif

endmodule

// File: tb/tb_program_counter.sv
// Scoreboard bench for program_counter: directed cases then randomized controls vs. an arithmetic model.
module tb_program_counter;

    typedef struct {
        logic [15:0] out;
        logic        wrap;
        logic [15:0] lj;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, clr, load, inc;
    logic [15:0] in, out, last_jump;
    logic        wrap;

    program_counter #(.WIDTH(16), .RESET_VEC(16'h0)) dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .load      (load),
        .inc       (inc),
        .in        (in),
        .out       (out),
        .wrap      (wrap),
        .last_jump (last_jump)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    exp_t        sb[$];
    int unsigned m_pc = 0;
    int unsigned m_lj = 0;
    exp_t        mon_e;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one edge's controls and predict the result from the plain priority rules.
    task automatic step(input logic c, input logic l, input logic i, input logic [15:0] d);
        exp_t e;
        @(negedge clk);
        clr = c; load = l; inc = i; in = d;
        e.wrap = 1'b0;
        if (c) begin
            m_pc = 0;
        end else if (l) begin
`ifdef PC_LAST_JUMP_EN
            m_lj = m_pc;
`endif
            m_pc = int'(d);
        end else if (i) begin
            e.wrap = (m_pc == 65535);
            m_pc   = (m_pc + 1) % 65536;
        end
        e.out = 16'(m_pc);
        e.lj  = 16'(m_lj);
        sb.push_back(e);
    endtask

    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            cmp("out",       {16'b0, out},       {16'b0, mon_e.out});
            cmp("wrap",      {31'b0, wrap},      {31'b0, mon_e.wrap});
            cmp("last_jump", {16'b0, last_jump}, {16'b0, mon_e.lj});
        end
    end

    initial begin
        rst = 1'b1; clr = 1'b0; load = 1'b0; inc = 1'b0; in = 16'h0;
        repeat (2) @(negedge clk);
        cmp("rst_out",  {16'b0, out},       32'h0);
        cmp("rst_wrap", {31'b0, wrap},      32'h0);
        cmp("rst_lj",   {16'b0, last_jump}, 32'h0);
        rst = 1'b0;

        step(0, 0, 1, 16'h0);
        step(0, 0, 1, 16'h0);
        step(0, 0, 1, 16'h0);
        step(0, 0, 0, 16'h0);
        step(0, 1, 1, 16'h1234);
        step(0, 0, 1, 16'h0);
        step(1, 1, 1, 16'h00FF);
        step(0, 1, 0, 16'hFFFF);
        step(0, 0, 1, 16'h0);
        step(0, 0, 0, 16'h0);
        step(0, 1, 0, 16'hFFFF);
        step(0, 1, 0, 16'h0000);
        step(0, 1, 0, 16'h0042);
        step(0, 0, 0, 16'h0);

        // Async reset between edges, with an inc pending that must not take effect.
        @(posedge clk);
        #3;
        inc = 1'b1;
        rst = 1'b1;
        #1;
        cmp("arst_out",  {16'b0, out},       32'h0);
        cmp("arst_wrap", {31'b0, wrap},      32'h0);
        cmp("arst_lj",   {16'b0, last_jump}, 32'h0);
        m_pc = 0;
        m_lj = 0;
        @(negedge clk);
        @(negedge clk);
        cmp("arst_hold", {16'b0, out}, 32'h0);
        rst = 1'b0;
        inc = 1'b0;

        step(0, 1, 0, 16'h0010);
        step(0, 1, 0, 16'h0200);
        step(0, 0, 1, 16'h0);

        for (int k = 0; k < 400; k++) begin
            logic        rc, rl, ri;
            logic [15:0] rd;
            rc = ($urandom_range(0, 99) < 5);
            rl = ($urandom_range(0, 99) < 15);
            ri = ($urandom_range(0, 99) < 70);
            rd = ($urandom_range(0, 3) == 0) ? 16'(16'hFFFF - $urandom_range(0, 2)) : 16'($urandom);
            step(rc, rl, ri, rd);
        end

        @(negedge clk);
        clr = 1'b0; load = 1'b0; inc = 1'b0;
        repeat (2) @(negedge clk);
        cmp("sb_drain", sb.size(), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
